// File: rtl/zaxxon_sound_pkg.sv
// Shared constants and types for the Zaxxon sound latch.
//   ADDR_*       : CPU register select codes
//   ONESHOT_W    : width of each one-shot down-counter
//   NUM_ONESHOT  : number of PORTB bits that own a one-shot
//   cpu_req_t    : one-cycle CPU bus request
package zaxxon_sound_pkg;

  localparam logic [1:0] ADDR_PORTA  = 2'd0;
  localparam logic [1:0] ADDR_PORTB  = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ONESHOT_W   = 16;
  localparam int NUM_ONESHOT = 4;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] addr;
    logic [7:0] din;
  } cpu_req_t;

endpackage

// File: rtl/zaxxon_oneshot.sv
// Retriggerable one-shot: loads LEN on fire, then counts down to zero.
//   clk_sys : system clock
//   reset   : synchronous active-high reset, clears the count
//   fire    : load LEN this edge (takes priority over decrement)
//   active  : high while the count is nonzero
module zaxxon_oneshot
  import zaxxon_sound_pkg::*;
#(
  parameter logic [ONESHOT_W-1:0] LEN = 16'd24000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic fire,
  output logic active
);

  logic [ONESHOT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset)            cnt <= '0;
    else if (fire)        cnt <= LEN;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  // LEN of zero loads zero, so no pulse is ever produced.
  assign active = (cnt != '0);

endmodule

// File: rtl/zaxxon_sound_latch.sv
// CPU-writable sound latch driving the discrete sound generator.
//   clk_sys  : system clock
//   reset    : synchronous active-high reset
//   cpu_wr   : write strobe (one cycle)
//   cpu_rd   : read strobe (one cycle)
//   cpu_addr : 0 PORTA, 1 PORTB, 2 MASK, 3 STATUS (read-only)
//   cpu_din  : write data
//   cpu_dout : registered read data
//   trig     : [3:0] level sounds from PORTA (active-low written),
//              [7:4] one-shots fired by PORTB 1->0 writes
module zaxxon_sound_latch
  import zaxxon_sound_pkg::*;
#(
  parameter logic [ONESHOT_W-1:0] ONESHOT_LEN = 16'd24000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic [7:0] trig
);

  cpu_req_t req;
  assign req = '{wr: cpu_wr, rd: cpu_rd, addr: cpu_addr, din: cpu_din};

  logic [7:0] porta, portb, mask;
  logic [NUM_ONESHOT-1:0] fire, active;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      porta <= 8'hFF;
      portb <= 8'hFF;
      mask  <= 8'hFF;
    end else if (req.wr) begin
      case (req.addr)
        ADDR_PORTA: porta <= req.din;
        ADDR_PORTB: portb <= req.din;
        ADDR_MASK:  mask  <= req.din;
        default:    ;
      endcase
    end
  end

  // Fire on a 1->0 transition of each low PORTB bit, judged against the
  // value held before this write.
  assign fire = {NUM_ONESHOT{req.wr && (req.addr == ADDR_PORTB)}}
              & portb[NUM_ONESHOT-1:0] & ~req.din[NUM_ONESHOT-1:0];

  zaxxon_oneshot #(.LEN(ONESHOT_LEN)) u_os [NUM_ONESHOT-1:0] (
    .clk_sys (clk_sys),
    .reset   (reset),
    .fire    (fire),
    .active  (active)
  );

  // Mask gates outputs only; masked one-shots keep counting.
  assign trig = {active & mask[7:4], ~porta[3:0] & mask[3:0]};

  logic [7:0] rd_mux;
  always_comb begin
    rd_mux = 8'h00;
    case (req.addr)
      ADDR_PORTA:  rd_mux = porta;
      ADDR_PORTB:  rd_mux = portb;
      ADDR_MASK:   rd_mux = mask;
      ADDR_STATUS: rd_mux = {4'b0000, active};
      default:     rd_mux = 8'h00;
    endcase
  end

  // A read colliding with a write is dropped.
  always_ff @(posedge clk_sys) begin
    if (reset)                   cpu_dout <= 8'h00;
    else if (req.rd && !req.wr)  cpu_dout <= rd_mux;
  end

endmodule

// File: tb/tb_zaxxon_sound_latch.sv
module tb_zaxxon_sound_latch;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       cpu_wr, cpu_rd;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic [7:0] cpu_dout, trig;
  logic [7:0] cpu_dout0, trig0;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  zaxxon_sound_latch #(.ONESHOT_LEN(16'd10)) dut (
    .clk_sys(clk_sys), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .trig(trig)
  );

  zaxxon_sound_latch #(.ONESHOT_LEN(16'd0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout0), .trig(trig0)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] trig;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive one cycle of bus activity, sample 1 time unit after the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [1:0] addr, input logic [7:0] din);
    cpu_wr = wr; cpu_rd = rd; cpu_addr = addr; cpu_din = din;
    @(posedge clk_sys); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
  endtask

  initial begin
    //           wr    rd    addr   din     trig   dout
    vecs[0]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'hFF};
    vecs[1]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'hFF};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFF};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 8'hFA, 8'h05, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 8'hFE, 8'h04, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 2'd2, 8'hFF, 8'h05, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h05, 8'hFA};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 8'h00, 8'h0F, 8'hFA};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h0F, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFF};

    reset = 1'b1;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 2'd0; cpu_din = 8'h00;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    chk("reset_trig", trig, 8'h00);
    chk("reset_dout", cpu_dout, 8'h00);

    foreach (vecs[i]) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
      chk($sformatf("vec%0d_trig", i), trig, vecs[i].trig);
      chk($sformatf("vec%0d_dout", i), cpu_dout, vecs[i].dout);
    end

    // Single pulse: exactly 10 cycles high, STATUS mid-pulse and after.
    cyc(1'b1, 1'b0, 2'd1, 8'hFE);
    chk("pulse_j0", trig, 8'h10);
    for (int j = 1; j <= 11; j++) begin
      cyc(1'b0, (j == 4), 2'd3, 8'h00);
      chk($sformatf("pulse_j%0d", j), trig, (j <= 9) ? 8'h10 : 8'h00);
      if (j == 4) chk("status_mid", cpu_dout, 8'h01);
    end
    cyc(1'b0, 1'b1, 2'd3, 8'h00);
    chk("status_after", cpu_dout, 8'h00);

    // Retrigger: FE@0, FF@4, FE@6 reloads, repeated FE@8 does not extend.
    cyc(1'b1, 1'b0, 2'd1, 8'hFF);
    chk("rearm", trig, 8'h00);
    for (int j = 0; j <= 17; j++) begin
      if (j == 0 || j == 4 || j == 6 || j == 8)
        cyc(1'b1, 1'b0, 2'd1, (j == 4) ? 8'hFF : 8'hFE);
      else
        cyc(1'b0, 1'b0, 2'd0, 8'h00);
      chk($sformatf("retrig_j%0d", j), trig, (j < 16) ? 8'h10 : 8'h00);
    end

    // Masked one-shot keeps counting; unmasking exposes the remainder.
    cyc(1'b1, 1'b0, 2'd1, 8'hFF);
    cyc(1'b1, 1'b0, 2'd2, 8'hEF);
    cyc(1'b1, 1'b0, 2'd1, 8'hFE);
    chk("masked_trig", trig, 8'h00);
    cyc(1'b0, 1'b1, 2'd3, 8'h00);
    chk("masked_status", cpu_dout, 8'h01);
    cyc(1'b1, 1'b0, 2'd2, 8'hFF);
    chk("unmask_trig", trig, 8'h10);
    repeat (12) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    chk("unmask_drain", trig, 8'h00);

    // Reset, then first F0 write fires all four one-shots.
    reset = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    chk("reset2_trig", trig, 8'h00);
    chk("reset2_dout", cpu_dout, 8'h00);
    cyc(1'b1, 1'b0, 2'd1, 8'hF0);
    chk("f0_fire", trig, 8'hF0);
    chk("len0_nopulse", trig0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 2'd0, 8'h00);
    chk("f0_mid", trig, 8'hF0);
    chk("len0_mid", trig0, 8'h00);

    // Reset mid-pulse kills all one-shots at that edge.
    reset = 1'b1;
    cyc(1'b0, 1'b0, 2'd0, 8'h00);
    reset = 1'b0;
    chk("reset_midpulse", trig, 8'h00);
    cyc(1'b0, 1'b1, 2'd3, 8'h00);
    chk("reset_status", cpu_dout, 8'h00);
    chk("reset_trig_hold", trig, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zaxxon_sound_latch.md
ZAXXON_SOUND_LATCH -- requirements
Module: zaxxon_sound_latch

Interface
REQ-001 Parameter ONESHOT_LEN, default 16'd24000, one-shot hold length in clk_sys cycles (0.5 ms at 48 MHz).
REQ-002 Port clk_sys  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port cpu_wr  input  1  write strobe, one clk_sys cycle per write.
REQ-005 Port cpu_rd  input  1  read strobe, one clk_sys cycle per read.
REQ-006 Port cpu_addr  input  2  register select: 0 PORTA, 1 PORTB, 2 MASK, 3 STATUS (read-only).
REQ-007 Port cpu_din  input  8  write data.
REQ-008 Port cpu_dout  output  8  registered read data.
REQ-009 Port trig  output  8  sound triggers to the discrete sound generator, active-high.

Function
REQ-010 PORTA, PORTB and MASK SHALL each be 8-bit registers, loaded from cpu_din at the edge where cpu_wr=1 and cpu_addr selects them.
REQ-011 A write to address 3 SHALL be ignored.
REQ-012 trig[3:0] SHALL equal ~PORTA[3:0] & MASK[3:0], combinational from registers, so it changes 1 cycle after the write edge. These are level sounds; the CPU writes them active-low.
REQ-013 PORTA[7:4] SHALL be stored and readable but drive no output.
REQ-014 Each PORTB bit i (i=0..3) SHALL own a 16-bit down-counter cnt[i].
REQ-015 cnt[i] SHALL load ONESHOT_LEN at a write edge to PORTB where the old PORTB[i]=1 and cpu_din[i]=0 (falling edge).
REQ-016 A 0->0, 1->1 or 0->1 write SHALL NOT load cnt[i].
REQ-017 When not loading, cnt[i] SHALL decrement by 1 per cycle while nonzero and hold at 0.
REQ-018 trig[4+i] SHALL equal (cnt[i]!=0) & MASK[4+i]; after a falling edge at edge k it is high for exactly ONESHOT_LEN cycles.
REQ-019 Retrigger: a falling edge while cnt[i]!=0 SHALL reload ONESHOT_LEN; the pulse extends with no low gap.
REQ-020 Masking SHALL gate outputs only: a masked one-shot still loads and counts, and unmasking mid-pulse exposes the remaining count.
REQ-021 ONESHOT_LEN=0 SHALL produce no one-shot pulses.
REQ-022 PORTB[7:4] SHALL be stored and readable but drive no output.
REQ-023 A read (cpu_rd=1 at edge k) SHALL update cpu_dout after edge k with the selected register: PORTA, PORTB, MASK, or STATUS = {4'b0000, cnt[3]!=0, cnt[2]!=0, cnt[1]!=0, cnt[0]!=0}.
REQ-024 cpu_dout SHALL hold its value when cpu_rd=0.
REQ-025 When cpu_wr=1 and cpu_rd=1 in the same cycle, the write SHALL occur and cpu_dout SHALL hold its prior value (the read is dropped).
REQ-026 A PORTB falling-edge write in the same cycle as a counter decrement SHALL reload; the load takes priority.

Reset
REQ-027 While reset=1 at an edge, the block SHALL set PORTA=8'hFF, PORTB=8'hFF, MASK=8'hFF, all cnt=0 and cpu_dout=8'h00, ignoring cpu_wr and cpu_rd.
REQ-028 After reset, trig SHALL be 8'h00.
REQ-029 Reset asserted mid-pulse SHALL terminate all one-shots at that edge.
REQ-030 The first PORTB write of 8'hF0 after reset SHALL fire one-shots 0..3, because reset leaves the PORTB bits at 1.

Structure
REQ-031 Package zaxxon_sound_pkg SHALL hold the address constants (ADDR_PORTA=0, ADDR_PORTB=1, ADDR_MASK=2, ADDR_STATUS=3) and the ONESHOT_W=16 width constant.
REQ-032 Sub-module zaxxon_oneshot (inputs clk_sys, reset, fire; output active; parameter LEN) SHALL be instantiated 4 times for the PORTB one-shots.
REQ-033 No other clocks, clock enables or asynchronous logic SHALL exist.

Verification
REQ-034 Reset, then no writes -> trig=8'h00, and reads of addr 0/1/2/3 return FF/FF/FF/00 one cycle after cpu_rd.
REQ-035 Write PORTA=8'hFA -> trig[3:0]=4'b0101 from the next cycle; then MASK=8'hFE -> trig[3:0]=4'b0100.
REQ-036 With ONESHOT_LEN=10, write PORTB=8'hFE -> trig[4] high for exactly 10 cycles; STATUS reads 8'h01 mid-pulse and 8'h00 after the pulse.
REQ-037 With ONESHOT_LEN=10, write PORTB=8'hFE, then 8'hFF at cycle 4, then 8'hFE at cycle 6 -> trig[4] stays high continuously until cycle 16; a repeated 8'hFE write does not extend the pulse.
REQ-038 Simultaneous cpu_wr and cpu_rd to PORTA with din=8'h00 -> PORTA=8'h00 and cpu_dout unchanged; reset asserted during an active pulse -> trig=8'h00 at the next cycle.
